// File: rtl/dmem_lane_adapter_if.sv
`timescale 1ns/1ps
// Wishbone request/response bundle used on both sides of dmem_lane_adapter.
// master drives the request fields; slave drives read data and the response.
interface dmem_lane_adapter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, addr, sel, data_wr, input data_rd, ack, err);
    modport slave  (input cyc, stb, we, addr, sel, data_wr, output data_rd, ack, err);
endinterface

// File: rtl/dmem_lane_adapter.sv
`timescale 1ns/1ps
// Byte-lane steering between dmembus and the data-side Wishbone target.
// Optional DMEM_TIMEOUT_EN turns a target silent for TIMEOUT_CYCLES BUSY cycles into err.
module dmem_lane_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    dmem_lane_adapter_if.slave  up,
    dmem_lane_adapter_if.master dn
);
    typedef enum logic [1:0] {IDLE, BUSY, MERR} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e      state, state_n;
    size_e       size, size_r;
    logic [1:0]  off, off_r;
    logic [31:0] addr_r, data_wr_r;
    logic [3:0]  sel_r;
    logic        we_r;
    logic        req, misalign, live, resp, timeout, accept, load;
    logic [31:0] rd_shifted, rd_mask;
`ifdef DMEM_TIMEOUT_EN
    logic [15:0] cnt;
`endif

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    always_comb begin
        req = up.cyc & up.stb;
        off = up.addr[1:0];
        case (up.sel)
            4'b0001: size = SZ_BYTE;
            4'b0011: size = SZ_HALF;
            default: size = SZ_WORD;
        endcase
        misalign = ((size == SZ_HALF) & off[0]) | ((size == SZ_WORD) & (off != 2'd0));
        // An upstream abort (cyc low) masks the target entirely, including a same-cycle ack.
        live     = (state == BUSY) & up.cyc;
        resp     = live & (dn.ack | dn.err);
`ifdef DMEM_TIMEOUT_EN
        timeout  = live & ~(dn.ack | dn.err) & (cnt == TIMEOUT_CYCLES[15:0]);
`else
        timeout  = 1'b0;
`endif
        accept   = req & ((state == IDLE) | resp);
        load     = accept & ~misalign;

        state_n = state;
        if (accept)
            state_n = misalign ? MERR : BUSY;
        else if (state == MERR || (state == BUSY && (!up.cyc || resp || timeout)))
            state_n = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            addr_r    <= '0;
            sel_r     <= '0;
            data_wr_r <= '0;
            we_r      <= 1'b0;
            off_r     <= '0;
            size_r    <= SZ_BYTE;
        end else begin
            state <= state_n;
            if (load) begin
                addr_r    <= {up.addr[31:2], 2'b00};
                sel_r     <= up.sel << off;
                data_wr_r <= up.data_wr << {off, 3'b000};
                we_r      <= up.we;
                off_r     <= off;
                size_r    <= size;
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (state == BUSY && state_n == BUSY && !load)
            cnt <= cnt + 16'd1;
        else
            cnt <= '0;
    end
`endif

    always_comb begin
        case (size_r)
            SZ_BYTE: rd_mask = 32'h0000_00FF;
            SZ_HALF: rd_mask = 32'h0000_FFFF;
            default: rd_mask = '1;
        endcase
    end

    assign rd_shifted = dn.data_rd >> {off_r, 3'b000};

    assign dn.cyc     = live;
    assign dn.stb     = live;
    assign dn.we      = we_r;
    assign dn.addr    = addr_r;
    assign dn.sel     = sel_r;
    assign dn.data_wr = data_wr_r;

    // Simultaneous ack and err resolves to err.
    assign up.ack     = live & dn.ack & ~dn.err;
    assign up.err     = (state == MERR) | (live & dn.err) | timeout;
    assign up.data_rd = live ? (rd_shifted & rd_mask) : '0;
endmodule

// File: tb/tb_dmem_lane_adapter.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_lane_adapter: byte-addressed reference memory on the
// request side, lane-addressed target memory on the downstream side.
module tb_dmem_lane_adapter;
    localparam int unsigned TO = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    dmem_lane_adapter_if up_bus ();
    dmem_lane_adapter_if dn_bus ();

    dmem_lane_adapter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .up    (up_bus),
        .dn    (dn_bus)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
        int          kind;   // 0 ack, 1 err, 2 ack+err, 3 silent
        bit          b2b;
        bit          gap;
        bit          noresp;
    } txn_t;
    typedef struct { bit err; bit chk; logic [31:0] data; } up_exp_t;
    typedef struct { logic [31:0] addr; logic [3:0] sel; logic [31:0] data; bit we; } dn_exp_t;
    typedef struct { int lat; int kind; } plan_t;

    up_exp_t      up_q[$];
    dn_exp_t      dn_q[$];
    plan_t        plan_q[$];
    byte unsigned ref_mem[64];
    logic [31:0]  tgt_mem[16];
    int           checks = 0;
    int           errors = 0;
    bit           last_aligned = 0;
    int           last_kind = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {27'b0, dn_bus.cyc, dn_bus.stb, dn_bus.we, up_bus.ack, up_bus.err}, 32'h0);
        check({tag, "_dn_addr"}, dn_bus.addr, 32'h0);
        check({tag, "_dn_sel"}, {28'b0, dn_bus.sel}, 32'h0);
        check({tag, "_dn_data_wr"}, dn_bus.data_wr, 32'h0);
        check({tag, "_up_data_rd"}, up_bus.data_rd, 32'h0);
    endtask

    function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                                input logic [31:0] wd, input int lat, input int kind, input bit b2b);
        txn_t t;
        t.we = we; t.addr = addr; t.sel = sel; t.wdata = wd;
        t.lat = lat; t.kind = kind; t.b2b = b2b; t.gap = 0; t.noresp = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        t.we = 1'($urandom_range(0, 1));
        if (r < 4)      t.sel = 4'b0001;
        else if (r < 7) t.sel = 4'b0011;
        else if (r < 9) t.sel = 4'b1111;
        else begin
            t.sel = ($urandom_range(0, 1) == 1) ? 4'b0101 : 4'b0111;
            t.we  = 0;
        end
        a = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            if (t.sel == 4'b0011) a[0] = 1'b0;
            else if (t.sel != 4'b0001) a[1:0] = 2'b00;
        end
        t.addr  = a;
        t.wdata = $urandom;
        t.lat   = $urandom_range(0, 3);
        r = $urandom_range(0, 99);
        t.kind  = (r < 85) ? 0 : (r < 93) ? 1 : 2;
`ifdef DMEM_TIMEOUT_EN
        if (r >= 97) t.kind = 3;
`endif
        t.b2b    = 1'($urandom_range(0, 1));
        t.gap    = ($urandom_range(0, 3) == 0);
        t.noresp = 0;
        return t;
    endfunction

    // Drive a request and record what the target and the upstream side must see.
    task automatic issue(input txn_t t, output int exp_wait, output bit aligned);
        int off, nb, a6;
        bit mis;
        logic [31:0] wd, rd;
        up_exp_t ue;
        dn_exp_t de;
        plan_t p;
        off = int'(t.addr[1:0]);
        a6  = int'(t.addr[5:0]);
        nb  = (t.sel == 4'b0001) ? 1 : (t.sel == 4'b0011) ? 2 : 4;
        wd  = t.wdata;
        if (nb < 4) wd = wd & ((32'h1 << (8 * nb)) - 32'h1);
        mis = (nb == 2 && off % 2 == 1) || (nb == 4 && off != 0);
        up_bus.cyc = 1; up_bus.stb = 1; up_bus.we = t.we;
        up_bus.addr = t.addr; up_bus.sel = t.sel; up_bus.data_wr = wd;
        exp_wait = 0;
        aligned  = !mis;
        if (mis) begin
            ue.err = 1; ue.chk = 1; ue.data = 32'h0;
            up_q.push_back(ue);
        end else begin
            de.addr = {t.addr[31:2], 2'b00};
            de.we   = t.we;
            de.sel  = 4'b0;
            de.data = 32'h0;
            for (int i = 0; i < nb; i++) begin
                de.sel[off + i]          = 1'b1;
                de.data[8*(off+i) +: 8] = wd[8*i +: 8];
            end
            if (nb == 4) de.sel = t.sel;
            p.lat = t.lat; p.kind = t.kind;
            dn_q.push_back(de);
            plan_q.push_back(p);
            exp_wait = (t.kind == 3) ? int'(TO) : t.lat;
            if (!t.noresp) begin
                ue.err = (t.kind != 0); ue.chk = 0; ue.data = 32'h0;
                if (t.kind == 0) begin
                    rd = 32'h0;
                    for (int i = 0; i < nb; i++) begin
                        if (t.we) ref_mem[a6 + i] = wd[8*i +: 8];
                        rd[8*i +: 8] = ref_mem[a6 + i];
                    end
                    ue.chk = !t.we; ue.data = rd;
                end
                up_q.push_back(ue);
            end
        end
    endtask

    task automatic run(input txn_t t);
        int ew, w;
        bit al;
        issue(t, ew, al);
        @(posedge i_clk); #2;
        up_bus.stb = 0;
        w = 0;
        while (up_bus.ack !== 1'b1 && up_bus.err !== 1'b1 && w < 40) begin
            @(posedge i_clk); #2;
            w++;
        end
        check("resp_latency", w, ew);
        last_aligned = al;
        last_kind    = t.kind;
    endtask

    task automatic abort_test(input bit we, input logic [31:0] addr, input int lat);
        txn_t t;
        int ew;
        bit al;
        t = mk(we, addr, 4'b1111, 32'h5A5A_A5A5, lat, 0, 0);
        t.noresp = 1;
        issue(t, ew, al);
        @(posedge i_clk); #2;
        up_bus.stb = 0;
        check("abort_pre_busy", {31'b0, dn_bus.cyc}, 32'h1);
        @(posedge i_clk); #2;
        up_bus.cyc = 0;
        #1;
        check("abort_dn_cyc_stb", {30'b0, dn_bus.cyc, dn_bus.stb}, 32'h0);
        check("abort_up_resp", {30'b0, up_bus.ack, up_bus.err}, 32'h0);
        @(posedge i_clk); #2;
    endtask

    task automatic reset_test();
        txn_t t;
        int ew;
        bit al;
        t = mk(1, 32'hCAFE_0008, 4'b1111, 32'h1234_5678, 50, 0, 0);
        t.noresp = 1;
        issue(t, ew, al);
        @(posedge i_clk); #2;
        up_bus.stb = 0;
        @(posedge i_clk); #2;
        check("rst_pre_busy", {30'b0, dn_bus.cyc, dn_bus.we}, 32'h3);
        #1 i_rst = 1;
        #1 check_zero("rst_mid");
        up_bus.cyc = 0;
        @(posedge i_clk); #2;
        i_rst = 0;
        @(posedge i_clk); #2;
    endtask

    // Downstream target: lane-addressed memory following the queued plan.
    initial begin : target
        bit      active;
        int      wait_cnt;
        plan_t   p;
        dn_exp_t cur;
        active = 0; wait_cnt = 0; p.lat = 0; p.kind = 0;
        dn_bus.ack = 0; dn_bus.err = 0; dn_bus.data_rd = 32'h0;
        forever begin
            @(posedge i_clk); #1;
            dn_bus.ack = 0; dn_bus.err = 0; dn_bus.data_rd = $urandom;
            if (dn_bus.cyc === 1'b1 && dn_bus.stb === 1'b1) begin
                if (!active) begin
                    active = 1;
                    if (plan_q.size() == 0 || dn_q.size() == 0) begin
                        check("unplanned_dn_cycle", {31'b0, dn_bus.cyc}, 32'h0);
                        p.kind = 3;
                        cur.addr = dn_bus.addr; cur.sel = dn_bus.sel;
                        cur.data = dn_bus.data_wr; cur.we = dn_bus.we;
                    end else begin
                        p   = plan_q.pop_front();
                        cur = dn_q.pop_front();
                        check("dn_addr", dn_bus.addr, cur.addr);
                        check("dn_sel", {28'b0, dn_bus.sel}, {28'b0, cur.sel});
                        check("dn_data_wr", dn_bus.data_wr, cur.data);
                        check("dn_we", {31'b0, dn_bus.we}, {31'b0, cur.we});
                    end
                    wait_cnt = p.lat;
                end else begin
                    check("dn_hold_addr", dn_bus.addr, cur.addr);
                    check("dn_hold_ctl", {27'b0, dn_bus.sel, dn_bus.we}, {27'b0, cur.sel, cur.we});
                    check("dn_hold_data", dn_bus.data_wr, cur.data);
                end
                if (p.kind != 3) begin
                    if (wait_cnt == 0) begin
                        case (p.kind)
                            0: begin
                                dn_bus.ack = 1;
                                if (cur.we) begin
                                    for (int j = 0; j < 4; j++)
                                        if (dn_bus.sel[j]) tgt_mem[dn_bus.addr[5:2]][8*j +: 8] = dn_bus.data_wr[8*j +: 8];
                                end else begin
                                    dn_bus.data_rd = tgt_mem[dn_bus.addr[5:2]];
                                end
                            end
                            1: dn_bus.err = 1;
                            default: begin dn_bus.ack = 1; dn_bus.err = 1; end
                        endcase
                        active = 0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                active = 0;
            end
        end
    end

    always @(negedge i_clk) begin : monitor
        up_exp_t e;
        if (i_rst === 1'b0 && (up_bus.ack === 1'b1 || up_bus.err === 1'b1)) begin
            if (up_q.size() == 0) begin
                check("unexpected_resp", {30'b0, up_bus.ack, up_bus.err}, 32'h0);
            end else begin
                e = up_q.pop_front();
                check("resp_kind", {30'b0, up_bus.ack, up_bus.err}, e.err ? 32'd1 : 32'd2);
                if (e.chk) check("rd_data", up_bus.data_rd, e.data);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        txn_t list[$];
        txn_t t;
        up_bus.cyc = 0; up_bus.stb = 0; up_bus.we = 0;
        up_bus.addr = 32'h0; up_bus.sel = 4'h0; up_bus.data_wr = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) tgt_mem[i] = 32'h0;

        repeat (2) @(posedge i_clk);
        #2 check_zero("reset");
        i_rst = 0;
        @(posedge i_clk); #2;

        list.push_back(mk(1, 32'h0000_1003, 4'b0001, 32'h0000_00AB, 0, 0, 0));
        list.push_back(mk(1, 32'h0000_2000, 4'b1111, 32'hBEEF_1234, 1, 0, 0));
        list.push_back(mk(0, 32'h0000_2002, 4'b0011, 32'h0, 2, 0, 0));
        list.push_back(mk(0, 32'h0000_3001, 4'b1111, 32'h0, 0, 0, 0));
        list.push_back(mk(0, 32'h0000_3003, 4'b0011, 32'h0, 0, 0, 0));
        list.push_back(mk(1, 32'h0000_0010, 4'b1111, 32'h0102_0304, 2, 0, 0));
        list.push_back(mk(0, 32'h0000_0020, 4'b1111, 32'h0, 0, 0, 1));
        list.push_back(mk(0, 32'h0000_1003, 4'b0001, 32'h0, 1, 1, 0));
        list.push_back(mk(0, 32'h0000_1002, 4'b0011, 32'h0, 0, 2, 0));
`ifdef DMEM_TIMEOUT_EN
        list.push_back(mk(0, 32'h0000_0040, 4'b1111, 32'h0, 0, 3, 0));
        list.push_back(mk(0, 32'h0000_2000, 4'b1111, 32'h0, 0, 0, 0));
`endif
        for (int i = 0; i < 300; i++) list.push_back(rand_txn());

        foreach (list[k]) begin
            t = list[k];
            if (!(k > 0 && t.b2b && last_aligned && last_kind != 3)) begin
                if (k > 0) begin @(posedge i_clk); #2; end
                up_bus.stb = 0;
                if (t.gap) begin
                    up_bus.cyc = 0;
                    @(posedge i_clk); #2;
                end
            end
            run(t);
        end
        @(posedge i_clk); #2;
        up_bus.cyc = 0;
        @(posedge i_clk); #2;

        abort_test(1, 32'h0000_0030, 50);
        abort_test(0, 32'h0000_0034, 1);
        reset_test();

        run(mk(0, 32'h0000_2000, 4'b1111, 32'h0, 0, 0, 0));
        @(posedge i_clk); #2;
        run(mk(0, 32'h0000_1001, 4'b0001, 32'h0, 1, 0, 0));
        @(posedge i_clk); #2;
        up_bus.cyc = 0;
        repeat (3) @(posedge i_clk);
        #2;
        check("leftover_up_q", up_q.size(), 32'h0);
        check("leftover_dn_q", dn_q.size(), 32'h0);
        check("leftover_plan_q", plan_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
